// File: rtl/dna_pkg.sv
// Shared constants, the nucleotide alphabet and the decoder state type for
// the DNA-to-binary read path.
package dna_pkg;

  localparam int ASCII_SIZE    = 8;
  localparam int BYTE_SIZE     = 8;
  localparam int GROUP_LETTERS = 5;
  localparam int NUM_BYTES     = 8;

  localparam int GROUP_W = GROUP_LETTERS * ASCII_SIZE;   // 40 bits per group
  localparam int DNA_W   = NUM_BYTES * GROUP_W;          // 320-bit strand
  localparam int MSG_W   = NUM_BYTES * BYTE_SIZE;        // 64-bit message
  localparam int GRP_W   = $clog2(NUM_BYTES);            // group index width

  // Position in this table is the 2-bit value a letter carries.
  localparam logic [ASCII_SIZE-1:0] NUCLEOTIDES [4] = '{"A", "C", "G", "T"};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    DECODE = 2'd2
  } dna_state_e;

endpackage

// File: rtl/dna_to_bin_if.sv
// Bus between the strand source and the DNA-to-binary decoder.
//
// Handshake: there is no valid/ready pair. 'start' is a level; the decoder
// accepts a job only on a 0->1 transition of 'start' seen while idle, and it
// samples 'dna' on that same clock edge. 'busy' is high until the job ends;
// 'finish_flag' then rises and the results stay stable until the next
// accepted start. 'state_dbg' mirrors the decoder FSM for observation only.
interface dna_to_bin_if;
  import dna_pkg::*;

  logic                 start;
  logic [DNA_W-1:0]     dna;
  logic [MSG_W-1:0]     binary_message;
  logic                 finish_flag;
  logic                 busy;
  logic                 err_flag;
  logic [GRP_W-1:0]     err_group;
  dna_state_e           state_dbg;

  modport master (
    output start, dna,
    input  binary_message, finish_flag, busy, err_flag, err_group, state_dbg
  );

  modport slave (
    input  start, dna,
    output binary_message, finish_flag, busy, err_flag, err_group, state_dbg
  );

endinterface

// File: rtl/dna_letter_decode.sv
// Maps one ASCII letter to its 2-bit nucleotide value; anything outside
// A/C/G/T is flagged invalid and decodes as 0.
module dna_letter_decode
  import dna_pkg::*;
(
  input  logic [ASCII_SIZE-1:0] letter,
  output logic [1:0]            idx,
  output logic                  valid
);

  // Table lookup against the nucleotide alphabet.
  always_comb begin
    idx   = 2'd0;
    valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (letter == NUCLEOTIDES[i]) begin
        idx   = 2'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dna_to_bin.sv
// DNA strand to 64-bit message decoder. Walks the eight 5-letter groups from
// the highest index down, one group every two clocks (FETCH then DECODE).
// Optional build macro: DNA_CHECK_EN adds homopolymer/repeat pattern checks
// to the per-group error detection.
module dna_to_bin
  import dna_pkg::*;
(
  input  logic        clk,
  input  logic        resetN,
  dna_to_bin_if.slave bus
);

  dna_state_e             state_q,     state_d;
  logic                   start_d_q;
  logic [DNA_W-1:0]       dna_q,       dna_d;
  logic [GROUP_W-1:0]     group_q,     group_d;
  logic [GRP_W-1:0]       grp_q,       grp_d;
  logic [MSG_W-1:0]       msg_q,       msg_d;
  logic                   finish_q,    finish_d;
  logic                   err_q,       err_d;
  logic [GRP_W-1:0]       err_grp_q,   err_grp_d;

  logic [ASCII_SIZE-1:0]  letter [GROUP_LETTERS];
  logic [1:0]             idx    [GROUP_LETTERS];
  logic [GROUP_LETTERS-1:0] valid;
  logic [1:0]             low_bits;
  logic [BYTE_SIZE-1:0]   dec_byte;
  logic                   pattern_bad;
  logic                   group_bad;
  logic                   start_rise;

  // One letter decoder per letter position of the fetched group (L0 at LSB).
  for (genvar l = 0; l < GROUP_LETTERS; l++) begin : g_letter
    assign letter[l] = group_q[l*ASCII_SIZE +: ASCII_SIZE];
    dna_letter_decode u_dec (
      .letter (letter[l]),
      .idx    (idx[l]),
      .valid  (valid[l])
    );
  end

  // L2 is the spacer: the low data bits are L0 relative to it, mod 4.
  assign low_bits = idx[0] - idx[2];
  assign dec_byte = {idx[4], idx[3], idx[1], low_bits};

`ifdef DNA_CHECK_EN
  // Runs the encoder never produces: L4=L3=L2, or L1=L0.
  assign pattern_bad = ((letter[4] == letter[2]) && (letter[3] == letter[2])) ||
                       (letter[1] == letter[0]);
`else
  assign pattern_bad = 1'b0;
`endif

  assign group_bad  = !(&valid) || pattern_bad;
  assign start_rise = bus.start && !start_d_q;

  // Next-state and datapath updates; every register holds unless told otherwise.
  always_comb begin
    state_d   = state_q;
    dna_d     = dna_q;
    group_d   = group_q;
    grp_d     = grp_q;
    msg_d     = msg_q;
    finish_d  = finish_q;
    err_d     = err_q;
    err_grp_d = err_grp_q;
    case (state_q)
      IDLE: begin
        if (start_rise) begin
          dna_d     = bus.dna;
          grp_d     = GRP_W'(NUM_BYTES - 1);
          msg_d     = '0;
          finish_d  = 1'b0;
          err_d     = 1'b0;
          err_grp_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        group_d = dna_q[grp_q*GROUP_W +: GROUP_W];
        state_d = DECODE;
      end
      DECODE: begin
        msg_d[grp_q*BYTE_SIZE +: BYTE_SIZE] = dec_byte;
        if (group_bad) begin
          err_d = 1'b1;
          // Groups run high to low, so the first hit is the highest index.
          if (!err_q) err_grp_d = grp_q;
        end
        if (grp_q != '0) begin
          grp_d   = grp_q - 1'b1;
          state_d = FETCH;
        end else begin
          finish_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q   <= IDLE;
      start_d_q <= 1'b0;
      dna_q     <= '0;
      group_q   <= '0;
      grp_q     <= '0;
      msg_q     <= '0;
      finish_q  <= 1'b0;
      err_q     <= 1'b0;
      err_grp_q <= '0;
    end else begin
      state_q   <= state_d;
      start_d_q <= bus.start;
      dna_q     <= dna_d;
      group_q   <= group_d;
      grp_q     <= grp_d;
      msg_q     <= msg_d;
      finish_q  <= finish_d;
      err_q     <= err_d;
      err_grp_q <= err_grp_d;
    end
  end

  assign bus.binary_message = msg_q;
  assign bus.finish_flag    = finish_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.err_flag       = err_q;
  assign bus.err_group      = err_grp_q;
  assign bus.state_dbg      = state_q;

endmodule

// File: tb/tb_dna_to_bin.sv
// Bench for dna_to_bin: directed strands, a letter-level reference model
// with a job-countdown timing model, a per-cycle compare process and
// hand-computed literal expectations.
module tb_dna_to_bin;
  import dna_pkg::*;

  typedef struct packed {
    logic [63:0] msg;
    logic        err;
    logic [2:0]  grp;
  } exp_t;

  localparam logic [39:0] G_AACAC = "AACAC";
  localparam logic [39:0] G_TTCTA = "TTCTA";
  localparam logic [39:0] G_ACAGT = "ACAGT";
  localparam logic [39:0] G_AANAC = "AANAC";
  localparam logic [39:0] G_AAAAA = "AAAAA";
  localparam logic [39:0] G_TTTTT = "TTTTT";

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetN;
  dna_to_bin_if bus_if();

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  dna_to_bin dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus_if.slave)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int letter_val(input logic [7:0] c, output bit ok);
    string nuc = "ACGT";
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (c == nuc[i]) begin
        ok = 1'b1;
        return i;
      end
    end
    return 0;
  endfunction

  function automatic exp_t model(input logic [319:0] d);
    exp_t        r;
    logic [39:0] g;
    int          v [5];
    bit          ok [5];
    bit          bad;
    int          b;
    r = '0;
    for (int k = 7; k >= 0; k--) begin
      g = d[k*40 +: 40];
      bad = 1'b0;
      for (int j = 0; j < 5; j++) begin
        v[j] = letter_val(g[j*8 +: 8], ok[j]);
        if (!ok[j]) bad = 1'b1;
      end
`ifdef DNA_CHECK_EN
      if ((g[39:32] == g[23:16] && g[31:24] == g[23:16]) || (g[15:8] == g[7:0])) bad = 1'b1;
`endif
      b = v[4]*64 + v[3]*16 + v[1]*4 + ((v[0] - v[2] + 4) % 4);
      r.msg[k*8 +: 8] = 8'(b);
      if (bad && !r.err) begin
        r.err = 1'b1;
        r.grp = 3'(k);
      end
    end
    return r;
  endfunction

  // Job timing: an accepted start yields finish 2*NUM_BYTES clocks later.
  int   m_cnt;
  logic m_start_d, m_finish, m_done;
  exp_t m_exp;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_cnt     <= 0;
      m_start_d <= 1'b0;
      m_finish  <= 1'b0;
      m_done    <= 1'b0;
      m_exp     <= '0;
    end else begin
      m_start_d <= bus_if.start;
      if (m_cnt == 0 && bus_if.start && !m_start_d) begin
        m_cnt    <= 2 * NUM_BYTES;
        m_finish <= 1'b0;
        m_done   <= 1'b0;
        m_exp    <= model(bus_if.dna);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_finish <= 1'b1;
          m_done   <= 1'b1;
        end
      end
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    check("busy", 64'(bus_if.busy), 64'(m_cnt != 0));
    check("finish_flag", 64'(bus_if.finish_flag), 64'(m_finish));
    check("state_idle", 64'(bus_if.state_dbg == IDLE), 64'(m_cnt == 0));
    if (m_cnt == 0) begin
      check("binary_message", bus_if.binary_message, m_done ? m_exp.msg : 64'h0);
      check("err_flag", 64'(bus_if.err_flag), 64'(m_done ? m_exp.err : 1'b0));
      check("err_group", 64'(bus_if.err_group), 64'(m_done ? m_exp.grp : 3'd0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_conv(input logic [319:0] d, output int lat);
    @(negedge clk);
    bus_if.dna   = d;
    bus_if.start = 1'b1;
    lat = -1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      if (bus_if.finish_flag) begin
        lat = c - 1;
        break;
      end
    end
    if (lat < 0) check("finish_timeout", 64'd1, 64'd0);
    @(negedge clk);
    bus_if.start = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  logic [319:0] d1, d2, d3, d4;
  exp_t         r;
  int           lat;
  int           rises;
  logic         prev_fin;

  initial begin
    resetN       = 1'b0;
    bus_if.start = 1'b0;
    bus_if.dna   = '0;

    d1 = {8{G_AACAC}};
    d2 = {G_TTCTA, G_ACAGT, {6{G_AACAC}}};
    d3 = d1;
    d3[5*40 +: 40] = G_AANAC;
    d4 = d1;
    d4[2*40 +: 40] = G_AAAAA;

    // Pin the model with hand-derived values.
    r = model(d1);
    check("model_t1_msg", r.msg, 64'h0);
    r = model(d2);
    check("model_t2_msg", r.msg, 64'hFF1B_0000_0000_0000);
    r = model(d3);
    check("model_t3_err", 64'(r.err), 64'd1);
    check("model_t3_grp", 64'(r.grp), 64'd5);

    @(negedge clk);
    #1;
    check("reset_msg", bus_if.binary_message, 64'h0);
    check("reset_finish", 64'(bus_if.finish_flag), 64'd0);
    check("reset_busy", 64'(bus_if.busy), 64'd0);
    check("reset_state", 64'(bus_if.state_dbg), 64'(IDLE));
    repeat (2) @(negedge clk);
    resetN = 1'b1;

    // 1: all-zero message, latency.
    run_conv(d1, lat);
    check("t1_latency", 64'(lat), 64'd16);
    check("t1_msg", bus_if.binary_message, 64'h0);
    check("t1_err", 64'(bus_if.err_flag), 64'd0);

    // 2: two non-trivial groups on top.
    run_conv(d2, lat);
    check("t2_msg", bus_if.binary_message, 64'hFF1B_0000_0000_0000);
    check("t2_err", 64'(bus_if.err_flag), 64'd0);

    // 3: invalid spacer in group 5; it decodes as 0 so the low bits are C-0 = 1.
    run_conv(d3, lat);
    check("t3_err", 64'(bus_if.err_flag), 64'd1);
    check("t3_grp", 64'(bus_if.err_group), 64'd5);
    check("t3_byte5", 64'(bus_if.binary_message[47:40]), 64'h01);
    check("t3_finish", 64'(bus_if.finish_flag), 64'd1);

    // 4: homopolymer group 2.
    run_conv(d4, lat);
`ifdef DNA_CHECK_EN
    check("t4_err", 64'(bus_if.err_flag), 64'd1);
    check("t4_grp", 64'(bus_if.err_group), 64'd2);
`else
    check("t4_err", 64'(bus_if.err_flag), 64'd0);
`endif
    check("t4_byte2", 64'(bus_if.binary_message[23:16]), 64'h00);

    // 5: extra start edge while busy, start held high, dna changed after accept.
    @(negedge clk);
    bus_if.dna   = d2;
    bus_if.start = 1'b1;
    prev_fin = bus_if.finish_flag;
    rises    = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.finish_flag && !prev_fin) rises++;
      prev_fin = bus_if.finish_flag;
      @(negedge clk);
      if (i == 2) bus_if.dna = {8{G_TTTTT}};
      bus_if.start = (i != 5);
    end
    bus_if.start = 1'b0;
    check("t5_finish_count", 64'(rises), 64'd1);
    check("t5_msg", bus_if.binary_message, 64'hFF1B_0000_0000_0000);

    // 6: reset at cycle 7 of a conversion, then a clean conversion.
    @(negedge clk);
    bus_if.dna   = d2;
    bus_if.start = 1'b1;
    repeat (7) @(posedge clk);
    #3;
    resetN       = 1'b0;
    bus_if.start = 1'b0;
    #1;
    check("t6_msg", bus_if.binary_message, 64'h0);
    check("t6_busy", 64'(bus_if.busy), 64'd0);
    check("t6_finish", 64'(bus_if.finish_flag), 64'd0);
    check("t6_err", 64'(bus_if.err_flag), 64'd0);
    check("t6_state", 64'(bus_if.state_dbg), 64'(IDLE));
    @(posedge clk);
    #3;
    resetN = 1'b1;
    run_conv(d3, lat);
    check("t6_latency", 64'(lat), 64'd16);
    check("t6_grp", 64'(bus_if.err_group), 64'd5);
    check("t6_byte5", 64'(bus_if.binary_message[47:40]), 64'h01);

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
